// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write for sub-word stores over a word-wide memory.
// Latency: error 1 cycle, load/word store 2 cycles, sub-word store 3 cycles to rsp_valid.
module lsu_rmw #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rd_word;

  logic        req_fire;
  logic        req_err;
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign req_fire = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= DEPTH_W) req_err = 1'b1;
  end

  // Lane offset in bits; halfwords are 2-byte aligned so the same shift serves both sizes.
  assign sh   = {lat_addr[1:0], 3'b000};
  assign lane = 16'(mem_rdata >> sh);

  always_comb begin
    case (lat_size)
      2'b00:   load_data = lat_signed ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      2'b01:   load_data = lat_signed ? {{16{lane[15]}}, lane} : {16'h0, lane};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    lane_mask = (lat_size == 2'b00) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
    if (lat_size == 2'b10) merged = lat_wdata;
    else                   merged = (rd_word & ~lane_mask) | ((lat_wdata << sh) & lane_mask);
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign mem_we    = (state == WR);
  assign mem_addr  = (state == RD || state == WR) ? {2'b00, lat_addr[31:2]} : 32'h0;
  assign mem_wdata = (state == WR) ? merged : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      rd_word    <= 32'h0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            rsp_rdata  <= 32'h0;
            rsp_err    <= req_err;
            if (req_err)                           state <= RSP;
            else if (req_we && req_size == 2'b10)  state <= WR;
            else                                   state <= RD;
          end
        end
        RD: begin
          rd_word <= mem_rdata;
          if (lat_we) begin
            state <= WR;
          end else begin
            rsp_rdata <= load_data;
            state     <= RSP;
          end
        end
        WR: state <= RSP;
        RSP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
